// File: rtl/quad_adder_if.sv
// quad_adder_if: operand/result bundle for quad_adder; SignedOverflow exists only with QUAD_ADDER_SOVF_EN
interface quad_adder_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic             Overflow;
  logic             out_valid;
`ifdef QUAD_ADDER_SOVF_EN
  logic             SignedOverflow;
  modport master (output in_valid, A, B, input Sum, Overflow, out_valid, SignedOverflow);
  modport slave  (input in_valid, A, B, output Sum, Overflow, out_valid, SignedOverflow);
`else
  modport master (output in_valid, A, B, input Sum, Overflow, out_valid);
  modport slave  (input in_valid, A, B, output Sum, Overflow, out_valid);
`endif
endinterface

// File: rtl/quad_adder.sv
// quad_adder: registered ripple-carry adder of two unsigned operands; QUAD_ADDER_SOVF_EN adds a signed-overflow flag
module quad_adder #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  quad_adder_if.slave bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d, vld_q, vld_d;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = bus.A[i] ^ bus.B[i] ^ c[i];
    assign c[i+1] = (bus.A[i] & bus.B[i]) | (bus.A[i] & c[i]) | (bus.B[i] & c[i]);
  end
  // next state: reset wins, a valid pair loads, otherwise results hold and valid drops
  always_comb begin
    sum_d = rst ? '0   : bus.in_valid ? s        : sum_q;
    ovf_d = rst ? 1'b0 : bus.in_valid ? c[WIDTH] : ovf_q;
    vld_d = !rst && bus.in_valid;
  end
  // result registers
  always_ff @(posedge clk) begin
    sum_q <= sum_d;
    ovf_q <= ovf_d;
    vld_q <= vld_d;
  end
  assign bus.Sum       = sum_q;
  assign bus.Overflow  = ovf_q;
  assign bus.out_valid = vld_q;
`ifdef QUAD_ADDER_SOVF_EN
  logic sovf_q, sovf_d;
  // signed overflow: carry into the sign bit differs from carry out of it
  always_comb sovf_d = rst ? 1'b0 : bus.in_valid ? c[WIDTH] ^ c[WIDTH-1] : sovf_q;
  // signed overflow register
  always_ff @(posedge clk) sovf_q <= sovf_d;
  assign bus.SignedOverflow = sovf_q;
`endif
endmodule

// File: tb/tb_quad_adder.sv
// tb_quad_adder: table-driven check of quad_adder plus reset/hold sequences (QUAD_ADDER_SOVF_EN checks the signed flag)
module tb_quad_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  quad_adder_if #(.WIDTH(4)) bus ();
  quad_adder #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       ovf;
    logic       sovf;
  } vec_t;

  task automatic chk(input string name, input logic [3:0] sum, input logic ovf, input logic vld, input logic sovf);
    logic [6:0] act, exp;
`ifdef QUAD_ADDER_SOVF_EN
    act = {bus.SignedOverflow, bus.out_valid, bus.Overflow, bus.Sum};
`else
    act = {sovf, bus.out_valid, bus.Overflow, bus.Sum};
`endif
    exp = {sovf, vld, ovf, sum};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sovf/vld/ovf/sum=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
               name, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    rst = r;
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt [10];
    vt[0] = '{4'd1,  4'd2,  4'd3,  1'b0, 1'b0};
    vt[1] = '{4'd15, 4'd1,  4'd0,  1'b1, 1'b0};
    vt[2] = '{4'd15, 4'd15, 4'd14, 1'b1, 1'b0};
    vt[3] = '{4'd8,  4'd8,  4'd0,  1'b1, 1'b1};
    vt[4] = '{4'd10, 4'd5,  4'd15, 1'b0, 1'b0};
    vt[5] = '{4'd14, 4'd1,  4'd15, 1'b0, 1'b0};
    vt[6] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
    vt[7] = '{4'd5,  4'd2,  4'd7,  1'b0, 1'b0};
    vt[8] = '{4'd2,  4'd3,  4'd5,  1'b0, 1'b0};
    vt[9] = '{4'd7,  4'd1,  4'd8,  1'b0, 1'b1};
    bus.in_valid = 1'b1;
    bus.A = 4'd15;
    bus.B = 4'd15;
    drive(1'b1, 1'b1, 4'd15, 4'd15);
    chk("reset_cycle1", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'd15, 4'd15);
    chk("reset_cycle2", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd9, 4'd9);
    chk("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_%0d+%0d", i, vt[i].a, vt[i].b), vt[i].sum, vt[i].ovf, 1'b1, vt[i].sovf);
    end
    drive(1'b0, 1'b1, 4'd7, 4'd1);
    chk("hold_load", 4'd8, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'd15, 4'd15);
      chk($sformatf("hold_idle%0d", i), 4'd8, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b1, 4'd15, 4'd1);
    chk("pre_midreset", 4'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'd15, 4'd15);
    chk("midreset", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'd8, 4'd8);
    chk("first_after_release", 4'd0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 4'd1, 4'd2);
    chk("back_to_back", 4'd3, 1'b0, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
